// File: rtl/div_ratio_sched.sv
// div_ratio_sched: lock-qualified programmable divider with glitch-free divisor updates.
// Revision: 1.0 - initial release.
`default_nettype none

module div_ratio_sched #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 8,
  parameter int LOCK_STABLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             out_wave,
  output logic             tick,
  output logic [WIDTH-1:0] active_div,
  output logic             running
);

  typedef enum logic [0:0] {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_t;

  localparam int                SW          = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
  localparam logic [SW-1:0]     STABLE_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [WIDTH-1:0]  DIV_RESET   = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0]  DIV_MIN     = WIDTH'(2);

  state_t           state_q, state_d;
  logic [SW-1:0]    stable_cnt_q, stable_cnt_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] active_div_q, active_div_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             pending_valid_q, pending_valid_d;

  logic             accept;
  logic             boundary;
  logic             qualified;
  logic [WIDTH-1:0] cfg_div_clamped;

  assign accept          = cfg_valid && !pending_valid_q;
  assign qualified       = locked && enable;
  assign cfg_div_clamped = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;
  // active_div is never below 2, so the subtraction cannot wrap.
  assign boundary        = (cnt_q == (active_div_q - WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= WAIT_LOCK;
      stable_cnt_q    <= '0;
      cnt_q           <= '0;
      active_div_q    <= DIV_RESET;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      stable_cnt_q    <= stable_cnt_d;
      cnt_q           <= cnt_d;
      active_div_q    <= active_div_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    stable_cnt_d    = stable_cnt_q;
    cnt_d           = cnt_q;
    active_div_d    = active_div_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;

    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        // A divisor left over from an interrupted run takes effect while idle.
        if (pending_valid_q) begin
          active_div_d    = pending_q;
          pending_valid_d = 1'b0;
        end else if (accept) begin
          active_div_d = cfg_div_clamped;
        end

        if (qualified) begin
          if (stable_cnt_q == STABLE_LAST) begin
            state_d      = RUN;
            stable_cnt_d = '0;
          end else begin
            stable_cnt_d = stable_cnt_q + SW'(1);
          end
        end else begin
          stable_cnt_d = '0;
        end
      end

      RUN: begin
        if (boundary) begin
          cnt_d = '0;
          if (pending_valid_q) begin
            active_div_d    = pending_q;
            pending_valid_d = 1'b0;
          end else if (accept) begin
            active_div_d = cfg_div_clamped;
          end
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
          if (accept) begin
            pending_d       = cfg_div_clamped;
            pending_valid_d = 1'b1;
          end
        end

        if (!qualified) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  assign running    = (state_q == RUN);
  assign cfg_ready  = !pending_valid_q;
  assign active_div = active_div_q;
  assign out_wave   = running && (cnt_q < (active_div_q >> 1));
  assign tick       = running && boundary;

endmodule

`default_nettype wire

// File: tb/tb_div_ratio_sched.sv
// tb_div_ratio_sched: directed self-checking bench for div_ratio_sched.
// Revision: 1.0 - initial release.
`default_nettype none

module tb_div_ratio_sched;

  logic        clk;
  logic        rst;
  logic        locked;
  logic        enable;
  logic        cfg_valid;
  logic [15:0] cfg_div;
  logic        cfg_ready;
  logic        out_wave;
  logic        tick;
  logic [15:0] active_div;
  logic        running;

  int n_checks = 0;
  int n_pass   = 0;

  div_ratio_sched #(
    .WIDTH(16),
    .DEFAULT_DIV(8),
    .LOCK_STABLE(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .locked    (locked),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .out_wave  (out_wave),
    .tick      (tick),
    .active_div(active_div),
    .running   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; locked = 1'b1; enable = 1'b1; cfg_valid = 1'b0; cfg_div = 16'd0;
    step(); step(); step();
    n_checks++; if (running !== 1'b0) $display("FAIL reset_running got %b exp 0", running); else n_pass++;
    n_checks++; if (out_wave !== 1'b0) $display("FAIL reset_wave got %b exp 0", out_wave); else n_pass++;
    n_checks++; if (tick !== 1'b0) $display("FAIL reset_tick got %b exp 0", tick); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", cfg_ready); else n_pass++;
    n_checks++; if (active_div !== 16'd8) $display("FAIL reset_div got %0d exp 8", active_div); else n_pass++;
  endtask

  task automatic test_lock_and_run();
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      n_checks++;
      if (running !== (i == 4)) $display("FAIL lock_delay i=%0d got %b exp %b", i, running, (i == 4));
      else n_pass++;
    end
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (out_wave !== ((k % 8) < 4)) $display("FAIL div8_wave k=%0d got %b exp %b", k, out_wave, ((k % 8) < 4));
      else n_pass++;
      n_checks++;
      if (tick !== ((k % 8) == 7)) $display("FAIL div8_tick k=%0d got %b exp %b", k, tick, ((k % 8) == 7));
      else n_pass++;
      step();
    end
  endtask

  task automatic test_change_mid_period();
    step(); step();
    cfg_valid = 1'b1; cfg_div = 16'd4;
    n_checks++; if (cfg_ready !== 1'b1) $display("FAIL mid_ready_before got %b exp 1", cfg_ready); else n_pass++;
    step();
    cfg_valid = 1'b0;
    n_checks++; if (cfg_ready !== 1'b0) $display("FAIL mid_ready_drop got %b exp 0", cfg_ready); else n_pass++;
    n_checks++; if (active_div !== 16'd8) $display("FAIL mid_div_held got %0d exp 8", active_div); else n_pass++;
    step(); step(); step(); step();
    n_checks++; if (tick !== 1'b1) $display("FAIL mid_last_tick got %b exp 1", tick); else n_pass++;
    n_checks++; if (active_div !== 16'd8) $display("FAIL mid_div_at_end got %0d exp 8", active_div); else n_pass++;
    step();
    n_checks++; if (active_div !== 16'd4) $display("FAIL mid_div_applied got %0d exp 4", active_div); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b1) $display("FAIL mid_ready_back got %b exp 1", cfg_ready); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (out_wave !== ((k % 4) < 2)) $display("FAIL div4_wave k=%0d got %b exp %b", k, out_wave, ((k % 4) < 2));
      else n_pass++;
      n_checks++;
      if (tick !== ((k % 4) == 3)) $display("FAIL div4_tick k=%0d got %b exp %b", k, tick, ((k % 4) == 3));
      else n_pass++;
      step();
    end
  endtask

  task automatic test_boundary_accept();
    step(); step(); step();
    cfg_valid = 1'b1; cfg_div = 16'd5;
    n_checks++; if (tick !== 1'b1) $display("FAIL bnd_tick got %b exp 1", tick); else n_pass++;
    step();
    cfg_valid = 1'b0;
    n_checks++; if (active_div !== 16'd5) $display("FAIL bnd_div got %0d exp 5", active_div); else n_pass++;
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (cfg_ready !== 1'b1) $display("FAIL bnd_ready k=%0d got %b exp 1", k, cfg_ready);
      else n_pass++;
      n_checks++;
      if (out_wave !== ((k % 5) < 2)) $display("FAIL div5_wave k=%0d got %b exp %b", k, out_wave, ((k % 5) < 2));
      else n_pass++;
      n_checks++;
      if (tick !== ((k % 5) == 4)) $display("FAIL div5_tick k=%0d got %b exp %b", k, tick, ((k % 5) == 4));
      else n_pass++;
      step();
    end
  endtask

  task automatic test_clamp();
    step(); step(); step(); step();
    cfg_valid = 1'b1; cfg_div = 16'd0;
    step();
    cfg_valid = 1'b0;
    n_checks++; if (active_div !== 16'd2) $display("FAIL clamp0_div got %0d exp 2", active_div); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (out_wave !== ((k % 2) == 0)) $display("FAIL div2_wave k=%0d got %b exp %b", k, out_wave, ((k % 2) == 0));
      else n_pass++;
      n_checks++;
      if (tick !== ((k % 2) == 1)) $display("FAIL div2_tick k=%0d got %b exp %b", k, tick, ((k % 2) == 1));
      else n_pass++;
      step();
    end
    step();
    cfg_valid = 1'b1; cfg_div = 16'd6;
    step();
    cfg_div = 16'd1;
    n_checks++; if (active_div !== 16'd6) $display("FAIL clamp_div6 got %0d exp 6", active_div); else n_pass++;
    step();
    cfg_valid = 1'b0;
    n_checks++; if (cfg_ready !== 1'b0) $display("FAIL clamp1_ready got %b exp 0", cfg_ready); else n_pass++;
    step(); step(); step(); step();
    n_checks++; if (tick !== 1'b1) $display("FAIL clamp_div6_tick got %b exp 1", tick); else n_pass++;
    step();
    n_checks++; if (active_div !== 16'd2) $display("FAIL clamp1_div got %0d exp 2", active_div); else n_pass++;
    n_checks++; if (out_wave !== 1'b1) $display("FAIL clamp1_wave0 got %b exp 1", out_wave); else n_pass++;
    step();
    n_checks++; if (out_wave !== 1'b0) $display("FAIL clamp1_wave1 got %b exp 0", out_wave); else n_pass++;
    n_checks++; if (tick !== 1'b1) $display("FAIL clamp1_tick got %b exp 1", tick); else n_pass++;
    step();
  endtask

  task automatic test_unlock_relock();
    cfg_valid = 1'b1; cfg_div = 16'd8;
    step();
    cfg_valid = 1'b0;
    step();
    n_checks++; if (active_div !== 16'd8) $display("FAIL unl_div8 got %0d exp 8", active_div); else n_pass++;
    step(); step(); step();
    locked = 1'b0;
    step();
    n_checks++; if (running !== 1'b0) $display("FAIL unl_running got %b exp 0", running); else n_pass++;
    n_checks++; if (tick !== 1'b0) $display("FAIL unl_tick got %b exp 0", tick); else n_pass++;
    n_checks++; if (out_wave !== 1'b0) $display("FAIL unl_wave got %b exp 0", out_wave); else n_pass++;
    locked = 1'b1;
    step(); step();
    locked = 1'b0;
    step(); step();
    n_checks++; if (running !== 1'b0) $display("FAIL glitch_running got %b exp 0", running); else n_pass++;
    locked = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      n_checks++;
      if (running !== (i == 4)) $display("FAIL relock_delay i=%0d got %b exp %b", i, running, (i == 4));
      else n_pass++;
    end
    n_checks++; if (out_wave !== 1'b1) $display("FAIL relock_wave got %b exp 1", out_wave); else n_pass++;
    step(); step();
  endtask

  task automatic test_rst_pending();
    cfg_valid = 1'b1; cfg_div = 16'd12;
    step();
    cfg_valid = 1'b0;
    n_checks++; if (cfg_ready !== 1'b0) $display("FAIL rstp_ready_pend got %b exp 0", cfg_ready); else n_pass++;
    rst = 1'b1;
    step();
    n_checks++; if (running !== 1'b0) $display("FAIL rstp_running got %b exp 0", running); else n_pass++;
    n_checks++; if (out_wave !== 1'b0) $display("FAIL rstp_wave got %b exp 0", out_wave); else n_pass++;
    n_checks++; if (tick !== 1'b0) $display("FAIL rstp_tick got %b exp 0", tick); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b1) $display("FAIL rstp_ready got %b exp 1", cfg_ready); else n_pass++;
    n_checks++; if (active_div !== 16'd8) $display("FAIL rstp_div got %0d exp 8", active_div); else n_pass++;
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      n_checks++;
      if (running !== (i == 4)) $display("FAIL rstp_lock i=%0d got %b exp %b", i, running, (i == 4));
      else n_pass++;
    end
    for (int k = 0; k < 7; k++) step();
    n_checks++; if (tick !== 1'b1) $display("FAIL rstp_tick7 got %b exp 1", tick); else n_pass++;
    step();
    n_checks++; if (active_div !== 16'd8) $display("FAIL rstp_pending_lost got %0d exp 8", active_div); else n_pass++;
    n_checks++; if (out_wave !== 1'b1) $display("FAIL rstp_wave0 got %b exp 1", out_wave); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lock_and_run();
    test_change_mid_period();
    test_boundary_accept();
    test_clamp();
    test_unlock_relock();
    test_rst_pending();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/div_ratio_sched.md
Name: div_ratio_sched

Overview:
Run-time controller for the board's programmable LED/clock-enable divider. It waits for the upstream MMCM to report a stable lock, then produces a square wave and a period tick from a counter. It also accepts new divide ratios over a valid/ready handshake and applies them only at a period boundary, so the output never glitches. It sits between the clocking primitives (MMCM lock, BUFR-driven clock) and the io_led outputs.

Parameters:
WIDTH, 16, width of divisor and internal counter
DEFAULT_DIV, 8, divide ratio loaded at reset (must be >= 2)
LOCK_STABLE, 4, consecutive cycles locked && enable must hold before running (>= 1)

Ports:
clk  input  1  single clock for all logic
rst  input  1  reset; synchronous, active-high
locked  input  1  MMCM lock indication, already in clk domain
enable  input  1  software run request
cfg_valid  input  1  new divisor offered
cfg_div  input  WIDTH  offered divisor
cfg_ready  output  1  controller can accept a divisor this cycle
out_wave  output  1  divided square wave
tick  output  1  high in the last cycle of each period
active_div  output  WIDTH  divisor currently in effect
running  output  1  high in RUN state

Behaviour:
- Reset values:
  - state=WAIT_LOCK, stable_cnt=0, cnt=0, pending_valid=0
  - active_div=DEFAULT_DIV, running=0, out_wave=0, tick=0, cfg_ready=1
- Clamping: cfg_div < 2 is clamped to 2 on acceptance. The stored/applied value is always >= 2.
- Handshake:
  - cfg_ready = !pending_valid (combinational).
  - Transfer occurs when cfg_valid && cfg_ready.
  - The offered value is ignored when cfg_ready=0; the sender must hold it.
- WAIT_LOCK:
  - running=0, cnt held at 0, out_wave=0, tick=0.
  - stable_cnt increments while locked && enable; it clears to 0 on any cycle either input is low.
  - When stable_cnt reaches LOCK_STABLE-1 with both inputs high: next state RUN, cnt=0, stable_cnt=0. RUN starts LOCK_STABLE cycles after both inputs are first seen high.
  - An accepted divisor goes straight into active_div on the next edge; pending_valid is not set.
- RUN:
  - running=1.
  - cnt increments by 1 each cycle. When cnt == active_div-1, cnt wraps to 0; this is the period boundary.
  - Period = active_div cycles.
  - out_wave = running && (cnt < active_div>>1), combinational from registers. High for floor(div/2) cycles, then low. Odd divisors are low for the longer half.
  - tick = running && (cnt == active_div-1).
- Divisor change in RUN:
  - An accepted divisor is stored in pending and sets pending_valid.
  - At the next boundary: active_div <= pending, pending_valid <= 0.
  - If the acceptance coincides with a boundary cycle (pending empty), the value is applied at that boundary directly and pending_valid stays 0.
  - Never changes active_div mid-period.
- Leaving RUN:
  - locked=0 or enable=0 in any RUN cycle: next cycle state=WAIT_LOCK, cnt=0, running=0.
  - No tick is emitted for the truncated period.
  - pending_valid and pending are retained. On entry to WAIT_LOCK, a retained pending value is copied to active_div one cycle later and pending_valid clears.
- rst asserted in any state overrides everything and returns all registers to reset values. Pending is discarded.
- Counter width: cnt is WIDTH bits. Divisors up to 2^WIDTH-1 must work with no overflow.

Test Plan:
1. Reset, then locked=1, enable=1 from cycle 0 -> running rises after exactly 4 cycles. With div 8: out_wave 1,1,1,1,0,0,0,0 repeating; tick every 8th cycle at cnt=7.
2. In RUN with div 8, at cnt=2 offer cfg_div=4 -> cfg_ready drops next cycle. Period completes as 8 cycles, then periods of 4 (out_wave 1,1,0,0). cfg_ready returns to 1 after the boundary.
3. Offer cfg_div=5 in the boundary cycle (cnt=7) -> next period is 5 cycles, out_wave 1,1,0,0,0. pending_valid never asserts (cfg_ready stays 1).
4. Offer cfg_div=0 and, separately, 1 -> active_div becomes 2; out_wave toggles every cycle; tick every 2nd cycle.
5. Deassert locked at cnt=3 -> running=0 and cnt=0 next cycle, no tick. Relock with a 2-cycle glitch low inside the stability window -> stable count restarts; RUN resumes 4 cycles after the last rise.
6. Assert rst while pending holds 12 and RUN is active -> all outputs return to reset values, active_div=8, cfg_ready=1, pending lost.
